// File: rtl/aes_ctrl_pkg.sv
// Shared constants and state encoding for the AES round control path.
package aes_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_INIT_ARK,
    ST_SUB,
    ST_SHIFT,
    ST_MIX,
    ST_ARK,
    ST_DONE
  } state_t;

  localparam int NR128 = 10;
  localparam int NR192 = 12;
  localparam int NR256 = 14;

  localparam int SBOX_CYCLES_DEF = 4;

  localparam logic ENCRYPT = 1'b1;

endpackage

// File: rtl/aes_round_counter.sv
// Round counter (0..NR, saturating at NR) plus S-box column sub-counter
// that cycles 0..SBOX_CYCLES-1 while the SubBytes step is running.
module aes_round_counter
  import aes_ctrl_pkg::*;
#(
  parameter int NR          = NR128,
  parameter int SBOX_CYCLES = SBOX_CYCLES_DEF
) (
  input  logic                     Clk,
  input  logic                     Rst,
  input  logic                     i_clear,
  input  logic                     i_round_inc,
  input  logic                     i_col_run,
  output logic [$clog2(NR+1)-1:0]  o_round,
  output logic                     o_round_last,
  output logic [1:0]               o_col,
  output logic                     o_col_last
);

  localparam int RW = $clog2(NR + 1);
  localparam logic [RW-1:0] ROUND_LAST = RW'(NR);
  localparam logic [1:0]    COL_LAST   = 2'(SBOX_CYCLES - 1);

  logic [RW-1:0] r_round;
  logic [1:0]    r_col;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values of its neighbours.
  always_ff @(posedge Clk) begin
    if (Rst || i_clear) begin
      r_round <= '0;
    end else if (i_round_inc && !o_round_last) begin
      r_round <= r_round + RW'(1);
    end
  end

  // Column index restarts at 0 on every entry into SubBytes.
  always_ff @(posedge Clk) begin
    if (Rst || !i_col_run || o_col_last) begin
      r_col <= '0;
    end else begin
      r_col <= r_col + 2'd1;
    end
  end

  assign o_round      = r_round;
  assign o_round_last = (r_round == ROUND_LAST);
  assign o_col        = r_col;
  assign o_col_last   = (r_col == COL_LAST);

endmodule

// File: rtl/aes_round_sequencer.sv
// Iterative AES round scheduler: walks the shared datapath through the
// encrypt or decrypt round sequence and holds the result until acknowledged.
module aes_round_sequencer
  import aes_ctrl_pkg::*;
#(
  parameter int NR          = NR128,
  parameter int SBOX_CYCLES = SBOX_CYCLES_DEF
) (
  input  logic                     Clk,
  input  logic                     Rst,
  input  logic                     i_Start,
  input  logic                     i_Mode,
  input  logic                     i_KeyValid,
  input  logic                     i_OutAck,
  output logic                     o_Busy,
  output logic                     o_OutValid,
  output logic                     o_LoadState,
  output logic                     o_SubEn,
  output logic [1:0]               o_SubCol,
  output logic                     o_ShiftEn,
  output logic                     o_MixEn,
  output logic                     o_AddKeyEn,
  output logic                     o_InvSel,
  output logic [$clog2(NR+1)-1:0]  o_RoundKeyAddr
);

  localparam int RW = $clog2(NR + 1);

  state_t        r_state;
  state_t        w_next;
  logic          r_mode;
  logic          r_busy;
  logic          r_out_valid;
  logic          r_load;
  logic          r_sub_en;
  logic          r_shift_en;
  logic          r_mix_en;
  logic          r_add_key_en;

  logic [RW-1:0] w_round;
  logic          w_round_last;
  logic [1:0]    w_col;
  logic          w_col_last;
  logic          w_enc;
  logic [1:0]    w_sub_col;
  logic          w_round_inc;

  assign w_enc = (r_mode == ENCRYPT);

  // Round number advances when leaving the initial key add and at the end of
  // each round: after ARK for encrypt, after MIX for decrypt.
  assign w_round_inc = (r_state == ST_INIT_ARK)
                    || (r_state == ST_ARK && w_enc && !w_round_last)
                    || (r_state == ST_MIX && !w_enc);

  aes_round_counter #(
    .NR          (NR),
    .SBOX_CYCLES (SBOX_CYCLES)
  ) u_round_counter (
    .Clk          (Clk),
    .Rst          (Rst),
    .i_clear      (r_state == ST_IDLE),
    .i_round_inc  (w_round_inc),
    .i_col_run    (r_state == ST_SUB),
    .o_round      (w_round),
    .o_round_last (w_round_last),
    .o_col        (w_col),
    .o_col_last   (w_col_last)
  );

  // NOTE: every variable driven here gets a default first, so no path
  // through the case can infer a latch.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:     if (i_Start && i_KeyValid) w_next = ST_LOAD;
      ST_LOAD:     w_next = ST_INIT_ARK;
      ST_INIT_ARK: w_next = w_enc ? ST_SUB : ST_SHIFT;
      ST_SUB:      if (w_col_last) w_next = w_enc ? ST_SHIFT : ST_ARK;
      ST_SHIFT:    w_next = !w_enc ? ST_SUB : (w_round_last ? ST_ARK : ST_MIX);
      ST_MIX:      w_next = w_enc ? ST_ARK : ST_SHIFT;
      ST_ARK:      w_next = w_round_last ? ST_DONE : (w_enc ? ST_SUB : ST_MIX);
      ST_DONE:     if (i_OutAck) w_next = ST_IDLE;
      default:     w_next = ST_IDLE;
    endcase
  end

  // Strobes are registered from the next state so they line up exactly with
  // r_state and with the counter values of the same cycle.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state      <= ST_IDLE;
      r_mode       <= ENCRYPT;
      r_busy       <= 1'b0;
      r_out_valid  <= 1'b0;
      r_load       <= 1'b0;
      r_sub_en     <= 1'b0;
      r_shift_en   <= 1'b0;
      r_mix_en     <= 1'b0;
      r_add_key_en <= 1'b0;
    end else begin
      if (r_state == ST_IDLE && i_Start && i_KeyValid) begin
        r_mode <= i_Mode;
      end
      r_state      <= w_next;
      r_busy       <= (w_next != ST_IDLE) && (w_next != ST_DONE);
      r_out_valid  <= (w_next == ST_DONE);
      r_load       <= (w_next == ST_LOAD);
      r_sub_en     <= (w_next == ST_SUB);
      r_shift_en   <= (w_next == ST_SHIFT);
      r_mix_en     <= (w_next == ST_MIX);
      r_add_key_en <= (w_next == ST_ARK) || (w_next == ST_INIT_ARK);
    end
  end

  // With two S-box strobes per step the datapath handles column pairs (0,1),(2,3).
  assign w_sub_col = (SBOX_CYCLES == 2) ? {w_col[0], 1'b0} : w_col;

  assign o_Busy         = r_busy;
  assign o_OutValid     = r_out_valid;
  assign o_LoadState    = r_load;
  assign o_SubEn        = r_sub_en;
  assign o_SubCol       = r_sub_en ? w_sub_col : 2'b00;
  assign o_ShiftEn      = r_shift_en;
  assign o_MixEn        = r_mix_en;
  assign o_AddKeyEn     = r_add_key_en;
  assign o_InvSel       = ~r_mode;
  assign o_RoundKeyAddr = r_add_key_en ? (w_enc ? w_round : RW'(NR) - w_round) : '0;

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Randomized bench for aes_round_sequencer: three parameterisations are
// compared cycle by cycle against a round-schedule list built from the cipher rules.
module tb_aes_round_sequencer;

  logic       Clk = 1'b0;
  logic       Rst;
  logic [2:0] start_v, mode_v, kv_v, ack_v;

  logic       busy_w [3];
  logic       ov_w   [3];
  logic       load_w [3];
  logic       sub_w  [3];
  logic [1:0] col_w  [3];
  logic       shift_w[3];
  logic       mix_w  [3];
  logic       ark_w  [3];
  logic       inv_w  [3];
  logic [3:0] addr_w [3];
  logic [13:0] obs   [3];

  int total = 0;
  int bad   = 0;

  logic [13:0] exp_q[$];

  always #5 Clk = ~Clk;

  function automatic int nr_of(input int d);
    case (d)
      0:       return 10;
      1:       return 14;
      default: return 12;
    endcase
  endfunction

  function automatic int s_of(input int d);
    case (d)
      0:       return 4;
      1:       return 1;
      default: return 2;
    endcase
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    aes_round_sequencer #(
      .NR          (nr_of(g)),
      .SBOX_CYCLES (s_of(g))
    ) u_dut (
      .Clk            (Clk),
      .Rst            (Rst),
      .i_Start        (start_v[g]),
      .i_Mode         (mode_v[g]),
      .i_KeyValid     (kv_v[g]),
      .i_OutAck       (ack_v[g]),
      .o_Busy         (busy_w[g]),
      .o_OutValid     (ov_w[g]),
      .o_LoadState    (load_w[g]),
      .o_SubEn        (sub_w[g]),
      .o_SubCol       (col_w[g]),
      .o_ShiftEn      (shift_w[g]),
      .o_MixEn        (mix_w[g]),
      .o_AddKeyEn     (ark_w[g]),
      .o_InvSel       (inv_w[g]),
      .o_RoundKeyAddr (addr_w[g])
    );
    assign obs[g] = {busy_w[g], ov_w[g], load_w[g], sub_w[g], col_w[g],
                     shift_w[g], mix_w[g], ark_w[g], inv_w[g], addr_w[g]};
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Bit layout: busy ov load sub col[1:0] shift mix ark inv addr[3:0]
  function automatic logic [13:0] vec(input bit busy, input bit ov, input bit load,
                                      input bit sub, input int col, input bit shift,
                                      input bit mix, input bit ark, input bit inv,
                                      input int addr);
    logic [1:0] c;
    logic [3:0] a;
    c = col[1:0];
    a = addr[3:0];
    return {busy, ov, load, sub, c, shift, mix, ark, inv, a};
  endfunction

  // Expected busy-cycle schedule, one entry per clock from LOAD to the final ARK.
  task automatic build(input int d, input bit m);
    int nr, s;
    nr = nr_of(d);
    s  = s_of(d);
    exp_q.delete();
    exp_q.push_back(vec(1, 0, 1, 0, 0, 0, 0, 0, !m, 0));
    exp_q.push_back(vec(1, 0, 0, 0, 0, 0, 0, 1, !m, m ? 0 : nr));
    for (int r = 1; r <= nr; r++) begin
      if (m) begin
        for (int c = 0; c < s; c++) exp_q.push_back(vec(1, 0, 0, 1, c * (4 / s), 0, 0, 0, 0, 0));
        exp_q.push_back(vec(1, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        if (r < nr) exp_q.push_back(vec(1, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        exp_q.push_back(vec(1, 0, 0, 0, 0, 0, 0, 1, 0, r));
      end else begin
        exp_q.push_back(vec(1, 0, 0, 0, 0, 1, 0, 0, 1, 0));
        for (int c = 0; c < s; c++) exp_q.push_back(vec(1, 0, 0, 1, c * (4 / s), 0, 0, 0, 1, 0));
        exp_q.push_back(vec(1, 0, 0, 0, 0, 0, 0, 1, 1, nr - r));
        if (r < nr) exp_q.push_back(vec(1, 0, 0, 0, 0, 0, 1, 0, 1, 0));
      end
    end
  endtask

  // Runs one request on DUT d; stop_at > 0 asserts Rst at that schedule index.
  task automatic run_txn(input int d, input bit m, input int stop_at);
    int          lat;
    bit          seen;
    int          hold;
    logic [13:0] dv, iv;
    build(d, m);
    seen = 0;
    lat  = 0;
    @(negedge Clk);
    start_v[d] = 1'b1;
    mode_v[d]  = m;
    kv_v[d]    = 1'b1;
    ack_v[d]   = 1'b0;
    @(negedge Clk);
    for (int i = 1; i <= 300; i++) begin
      if (i <= exp_q.size()) check($sformatf("trace d%0d m%0d i%0d", d, m, i), obs[d], exp_q[i-1]);
      if (stop_at != 0 && i == stop_at) begin
        Rst = 1'b1;
        @(negedge Clk);
        check($sformatf("rst_mid d%0d", d), obs[d], 14'h0);
        Rst        = 1'b0;
        start_v[d] = 1'b0;
        ack_v[d]   = 1'b0;
        return;
      end
      if (obs[d][12]) begin
        lat  = i - 1;
        seen = 1;
        break;
      end
      start_v[d] = 1'($urandom_range(0, 1));
      ack_v[d]   = 1'($urandom_range(0, 1));
      kv_v[d]    = 1'($urandom_range(0, 1));
      mode_v[d]  = 1'($urandom_range(0, 1));
      @(negedge Clk);
    end
    check($sformatf("latency d%0d m%0d", d, m), seen ? lat : 32'hFFFF_FFFF,
          2 + nr_of(d) * (s_of(d) + 3) - 1);
    dv   = vec(0, 1, 0, 0, 0, 0, 0, 0, !m, 0);
    iv   = vec(0, 0, 0, 0, 0, 0, 0, 0, !m, 0);
    hold = $urandom_range(1, 3);
    for (int h = 1; h <= hold; h++) begin
      check($sformatf("done_hold d%0d h%0d", d, h), obs[d], dv);
      start_v[d] = (h == hold) ? 1'b1 : 1'($urandom_range(0, 1));
      kv_v[d]    = 1'b1;
      ack_v[d]   = (h == hold);
      @(negedge Clk);
    end
    check($sformatf("ack_idle d%0d", d), obs[d], iv);
    start_v[d] = 1'b0;
    ack_v[d]   = 1'b0;
    @(negedge Clk);
    check($sformatf("no_restart d%0d", d), obs[d], iv);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    Rst     = 1'b1;
    start_v = '0;
    mode_v  = '0;
    kv_v    = '0;
    ack_v   = '0;
    repeat (3) @(negedge Clk);
    Rst = 1'b0;
    for (int c = 0; c < 20; c++) begin
      for (int d = 0; d < 3; d++) check($sformatf("reset_idle d%0d c%0d", d, c), obs[d], 14'h0);
      @(negedge Clk);
    end

    start_v[0] = 1'b1;
    kv_v[0]    = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge Clk);
      check($sformatf("no_key c%0d", c), obs[0], 14'h0);
    end
    start_v[0] = 1'b0;

    run_txn(0, 1'b1, 0);
    run_txn(0, 1'b0, 0);
    run_txn(1, 1'b1, 0);
    run_txn(1, 1'b0, 0);
    run_txn(2, 1'b1, 0);
    run_txn(2, 1'b0, 0);

    run_txn(0, 1'b1, 2 + 4 * (s_of(0) + 3) + 1);
    run_txn(0, 1'b1, 0);
    run_txn(1, 1'b0, 2 + 4 * (s_of(1) + 3) + 1);
    run_txn(1, 1'b1, 0);

    repeat (8) begin
      int d;
      d = $urandom_range(0, 2);
      run_txn(d, 1'($urandom_range(0, 1)), 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
